imem_fetch_ctrl: RTL and testbench

Fetch sequencer and access arbiter for the word-addressed instruction memory of the single-cycle processor. It owns the memory's address port and shares it between a host loader, which writes the program before execution, and the fetch path, which drives the PC. It presents a registered instruction stream to the decoder and handles stall, branch redirect, halt and out-of-range PC faults.

---
 rtl/imem_fetch_ctrl_if.sv | 26 ++
 rtl/imem_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - host loader write channel into the instruction memory
interface imem_fetch_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             load_valid;
  logic [AW-1:0]    load_addr;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  // Host loader side
  modport master (
    output load_valid,
    output load_addr,
    output load_data,
    input  load_ready
  );

  // Fetch controller side
  modport slave (
    input  load_valid,
    input  load_addr,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory fetch sequencer and host/fetch port arbiter
module imem_fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  imem_fetch_ctrl_if.slave load,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  output logic [1:0]       state,
  output logic             fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // Highest legal PC; a fetch at this address is the last one before running off the end
  localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(DEPTH - 1);

  state_t st;
  logic   host_owns_port;
  logic   load_fire;

  assign host_owns_port = (st == S_IDLE) || (st == S_LOAD);
  assign load.load_ready = host_owns_port;
  assign load_fire      = load.load_valid && host_owns_port;

  assign mem_we    = load_fire;
  assign mem_wdata = load.load_data;
  assign state     = st;

  // Address port belongs to the loader before execution and to the PC afterwards
  always_comb begin
    mem_addr = pc;
    if (host_owns_port) begin
      mem_addr = {{(WIDTH-AW){1'b0}}, load.load_addr};
    end
  end

  // Control FSM with registered fetch outputs; RUN priority is halt > branch > stall > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_LOAD: begin
          // A write in the same cycle as start wins; the host must re-assert start
          if (load_fire) begin
            st <= S_LOAD;
          end else if (start) begin
            st <= S_RUN;
            pc <= '0;
          end
        end
        S_RUN: begin
          if (halt_req) begin
            st          <= S_HALT;
            instr_valid <= 1'b0;
          end else if (branch_taken) begin
            instr_valid <= 1'b0;
            if (branch_target <= LAST_PC) begin
              pc <= branch_target;
            end else begin
              st    <= S_HALT;
              fault <= 1'b1;
            end
          end else if (!stall) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            // The last word is still delivered, but there is nothing legal to fetch after it
            if (pc >= LAST_PC) begin
              st    <= S_HALT;
              fault <= 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_HALT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stall, branch_taken, halt_req;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic             mem_we;
  logic [WIDTH-1:0] pc, instr, instr_pc;
  logic             instr_valid, fault;
  logic [1:0]       state;

  imem_fetch_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) lif ();

  imem_fetch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load(lif.slave),
    .start(start), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pc(pc), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous write, combinational read
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (mem_we) mem[mem_addr[AW-1:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[AW-1:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard of instructions expected to appear on the decoder stream
  typedef struct {
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] ipc;
  } sb_t;
  sb_t sb[$];

  logic             prev_v = 1'b0;
  logic [WIDTH-1:0] prev_ipc = '0;

  always @(negedge clk) begin
    if (instr_valid === 1'b1 && (!prev_v || instr_pc !== prev_ipc)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_instr", instr_pc, '1);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_instr", instr, e.ins);
        chk("sb_instr_pc", instr_pc, e.ipc);
      end
    end
    prev_v   <= instr_valid;
    prev_ipc <= instr_pc;
  end

  typedef struct {
    logic             rst, start, stall, br;
    logic [WIDTH-1:0] tgt;
    logic             halt;
    logic [1:0]       est;
    logic [WIDTH-1:0] epc;
    logic             ev;
    logic [WIDTH-1:0] eipc;
    logic             ef;
    logic             push;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic st, logic b, int t, logic h,
                              logic [1:0] es, int ep, logic ev, int ei, logic ef, logic pu);
    vec_t v;
    v = '{r, s, st, b, WIDTH'(t), h, es, WIDTH'(ep), ev, WIDTH'(ei), ef, pu};
    return v;
  endfunction

  initial begin
    //                  rst st stl br tgt hlt  est  pc  v  ipc f  push
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 2'd2,  0, 0,  0, 0, 0)); // start
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  1, 1,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  2, 1,  1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0,  0, 0, 2'd2,  2, 1,  1, 0, 0)); // stall x3
    vecs.push_back(mk(0, 0, 1, 0,  0, 0, 2'd2,  2, 1,  1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0, 0, 2'd2,  2, 1,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  3, 1,  2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  4, 1,  3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1,  7, 0, 2'd2,  7, 0,  0, 0, 0)); // branch under stall
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  8, 1,  7, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  9, 1,  8, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 29, 0, 2'd2, 29, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2, 30, 1, 29, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2, 31, 1, 30, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd3, 31, 1, 31, 1, 1)); // last word, run off end
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd3, 31, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1,  3, 0, 2'd3, 31, 0,  0, 1, 0)); // ignored in HALT
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 2'd0,  0, 0,  0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 2'd2,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  1, 1,  0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 2'd0,  0, 0,  0, 0, 0)); // reset mid-RUN
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 2'd2,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  1, 1,  0, 0, 1)); // re-reads loaded words
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  2, 1,  1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1,  5, 1, 2'd3,  2, 0,  0, 0, 0)); // halt beats branch/stall
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd3,  2, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 2'd0,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 2'd2,  0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd2,  1, 1,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 40, 0, 2'd3,  1, 0,  0, 1, 0)); // out-of-range branch
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 2'd3,  1, 0,  0, 1, 0));

    rst = 1'b1; start = 0; stall = 0; branch_taken = 0; halt_req = 0; branch_target = '0;
    lif.load_valid = 0; lif.load_addr = '0; lif.load_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", pc, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_instr_pc", instr_pc, 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_load_ready", 32'(lif.load_ready), 32'd1);

    // First write coincides with start: write wins, start dropped
    lif.load_valid = 1; lif.load_addr = 5'd0; lif.load_data = 32'hA0; start = 1;
    #1;
    chk("idle_mem_we", 32'(mem_we), 32'd1);
    chk("idle_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    chk("load_start_same_cycle_state", 32'(state), 32'd1);
    start = 0;
    for (int i = 1; i < DEPTH; i++) begin
      lif.load_addr = AW'(i); lif.load_data = 32'hA0 + 32'(i);
      #1;
      chk("load_mem_addr", mem_addr, 32'(i));
      @(posedge clk); #1;
    end
    chk("load_state", 32'(state), 32'd1);
    lif.load_valid = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stall = vecs[i].stall;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt; halt_req = vecs[i].halt;
      if (vecs[i].push) begin
        sb_t e;
        e.ins = 32'hA0 + vecs[i].eipc;
        e.ipc = vecs[i].eipc;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].est));
      chk($sformatf("v%0d_pc", i), pc, vecs[i].epc);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].ef));
      if (vecs[i].ev) chk($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].eipc);
    end
    rst = 0; start = 0; stall = 0; branch_taken = 0; halt_req = 0;

    // Host is locked out while halted
    lif.load_valid = 1; lif.load_addr = 5'd9; lif.load_data = 32'hDEAD; start = 1;
    #1;
    chk("halt_load_ready", 32'(lif.load_ready), 32'd0);
    chk("halt_mem_we", 32'(mem_we), 32'd0);
    chk("halt_mem_addr", mem_addr, 32'd1);
    @(posedge clk); #1;
    chk("halt_sticky_state", 32'(state), 32'd3);
    chk("halt_sticky_pc", pc, 32'd1);
    chk("mem_untouched", mem[9], 32'hA9);
    lif.load_valid = 0; start = 0;
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
